// File: rtl/uart_tx_stim.sv
// Bench-side 8N1 UART transmitter fed from a small byte queue.
// Bytes pushed via wr_en are shifted out on tx back-to-back, LSB first.
module uart_tx_stim #(
  parameter int unsigned DIV_RATE   = 260,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               tx_busy,
  output logic               tx_end,
  output logic               tx
);

  localparam int unsigned CW   = 16;
  localparam int unsigned CNTW = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [7:0]           mem [FIFO_DEPTH];

  logic                 bit_end_c;
  logic                 pop_c;
  logic                 push_c;
  logic [CNTW-1:0]      count_next_c;

  // Pop happens when leaving IDLE or at the end of a stop bit with work queued;
  // a push is allowed while full only if a pop frees a slot on the same edge.
  always_comb begin
    bit_end_c    = (baud_cnt == CW'(DIV_RATE - 1));
    pop_c        = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end_c));
    push_c       = wr_en && (!full || pop_c);
    count_next_c = count;
    if (push_c && !pop_c)
      count_next_c = count + CNTW'(1);
    else if (pop_c && !push_c)
      count_next_c = count - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      tx_busy  <= 1'b0;
      tx_end   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_end <= 1'b0;
      count  <= count_next_c;
      full   <= (count_next_c == CNTW'(FIFO_DEPTH));
      if (push_c)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)
        rd_ptr <= rd_ptr + FIFO_AW'(1);

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop_c) begin
            shreg   <= mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          // Registered pulse lands on the final cycle of the stop bit
          tx_end <= (baud_cnt == CW'(DIV_RATE - 2));
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop_c) begin
              shreg <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
